// File: rtl/mat_mul_pkg.sv
// Shared definitions for the systolic matrix-multiply datapath.
package mat_mul_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 32;

  // Result-register occupancy of the dot-product accumulator
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage : mat_mul_pkg

// File: rtl/group_counter.sv
// Modulo-K counter of absorbed products; wrap_c flags the K-th increment.
module group_counter #(
  parameter int unsigned K     = 8,
  parameter int unsigned CNT_W = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  // The increment that would reach K returns to zero instead
  assign wrap_c = en && !clr && (count == LAST);

  // Count register: sync clear has priority over enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule : group_counter

// File: rtl/dot_accumulator.sv
// Sums K valid products into one dot-product result held behind a valid/ready register.
module dot_accumulator #(
  parameter int unsigned PROD_W = mat_mul_pkg::PROD_W,
  parameter int unsigned ACC_W  = mat_mul_pkg::ACC_W,
  parameter int unsigned K      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PROD_W-1:0]        product,
  input  logic                     valid_in,
  input  logic                     clear,
  output logic [ACC_W-1:0]         sum,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic [$clog2(K+1)-1:0]   count,
  output logic                     overrun
);

  import mat_mul_pkg::*;

  localparam int unsigned CNT_W = $clog2(K + 1);

  // Reject configurations that could wrap the accumulator
  if (K < 1) begin : g_k_check
    $error("dot_accumulator: K must be at least 1");
  end
  if (ACC_W < PROD_W + $clog2(K)) begin : g_width_check
    $error("dot_accumulator: ACC_W too narrow for K products of PROD_W bits");
  end

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum_c;
  logic             done_c;
  logic             set_ovr_c;
  out_state_t       state_q;
  out_state_t       state_d;

  // Group position; a clear or reset restarts the group
  group_counter #(
    .K     (K),
    .CNT_W (CNT_W)
  ) u_group_counter (
    .clk    (clk),
    .rst    (rst),
    .en     (valid_in),
    .clr    (clear),
    .count  (count),
    .wrap_c (done_c)
  );

  assign acc_sum_c = acc_q + ACC_W'(product);
  assign sum_valid = (state_q == OUT_FULL);

  // Output FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a completion while FULL replaces the result, flagging loss if unaccepted
  always_comb begin
    state_d   = state_q;
    set_ovr_c = 1'b0;
    unique case (state_q)
      OUT_EMPTY: begin
        if (done_c) state_d = OUT_FULL;
      end
      OUT_FULL: begin
        if (done_c) begin
          state_d   = OUT_FULL;
          set_ovr_c = !sum_ready;
        end else if (sum_ready) begin
          state_d = OUT_EMPTY;
        end
      end
    endcase
  end

  // Accumulator, result register and sticky overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      sum     <= '0;
      overrun <= 1'b0;
    end else begin
      if (clear) begin
        acc_q <= '0;
      end else if (valid_in) begin
        acc_q <= done_c ? '0 : acc_sum_c;
      end
      if (done_c) begin
        sum <= acc_sum_c;
      end
      if (clear) begin
        overrun <= 1'b0;
      end else if (set_ovr_c) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule : dot_accumulator

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator with K=4 and K=8 instances sharing stimulus.
module tb_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] product;
  logic        valid_in;
  logic        clear;
  logic        sum_ready;

  logic [31:0] sum4, sum8;
  logic        sv4, sv8;
  logic [2:0]  cnt4;
  logic [3:0]  cnt8;
  logic        ov4, ov8;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] grp [4] = '{16'd91, 16'd65025, 16'd0, 16'd256};

  always #5 clk = ~clk;

  dot_accumulator #(.PROD_W(16), .ACC_W(32), .K(4)) u_k4 (
    .clk(clk), .rst(rst), .product(product), .valid_in(valid_in), .clear(clear),
    .sum(sum4), .sum_valid(sv4), .sum_ready(sum_ready), .count(cnt4), .overrun(ov4)
  );

  dot_accumulator #(.PROD_W(16), .ACC_W(32), .K(8)) u_k8 (
    .clk(clk), .rst(rst), .product(product), .valid_in(valid_in), .clear(clear),
    .sum(sum8), .sum_valid(sv8), .sum_ready(sum_ready), .count(cnt8), .overrun(ov8)
  );

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic step(input logic v, input logic [15:0] p, input logic c, input logic r);
    valid_in  = v;
    product   = p;
    clear     = c;
    sum_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; product = '0; valid_in = 1'b0; clear = 1'b0; sum_ready = 1'b0;
    #3;
    chk("rst_sum", sum4, 32'd0);
    chk("rst_sv", 32'(sv4), 32'd0);
    chk("rst_cnt", 32'(cnt4), 32'd0);
    chk("rst_ovr", 32'(ov4), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Back-to-back group, downstream always ready
    step(1'b1, 16'd91, 1'b0, 1'b1);    chk("t1_cnt1", 32'(cnt4), 32'd1);
    step(1'b1, 16'd65025, 1'b0, 1'b1); chk("t1_cnt2", 32'(cnt4), 32'd2);
    step(1'b1, 16'd0, 1'b0, 1'b1);     chk("t1_cnt3", 32'(cnt4), 32'd3);
    chk("t1_sv_early", 32'(sv4), 32'd0);
    step(1'b1, 16'd256, 1'b0, 1'b1);
    chk("t1_sv", 32'(sv4), 32'd1);
    chk("t1_sum", sum4, 32'd65372);
    chk("t1_cnt0", 32'(cnt4), 32'd0);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("t1_sv_drop", 32'(sv4), 32'd0);
    chk("t1_ovr", 32'(ov4), 32'd0);

    // Same group with two bubbles after each product
    for (int i = 0; i < 4; i++) begin
      step(1'b1, grp[i], 1'b0, 1'b0);
      chk("t2_cnt", 32'(cnt4), 32'((i + 1) % 4));
      for (int b = 0; b < 2; b++) begin
        step(1'b0, 16'hffff, 1'b0, 1'b0);
        chk("t2_hold", 32'(cnt4), 32'((i + 1) % 4));
      end
    end
    chk("t2_sv", 32'(sv4), 32'd1);
    chk("t2_sum", sum4, 32'd65372);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("t2_sv_drop", 32'(sv4), 32'd0);

    // Two groups, result never accepted: overwrite and overrun
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("t3_sum_a", sum4, 32'd10);
    chk("t3_ovr_a", 32'(ov4), 32'd0);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(10 * i), 1'b0, 1'b0);
    chk("t3_sum_b", sum4, 32'd100);
    chk("t3_sv_b", 32'(sv4), 32'd1);
    chk("t3_ovr_b", 32'(ov4), 32'd1);
    step(1'b0, 16'd0, 1'b1, 1'b0);
    chk("t3_clr_ovr", 32'(ov4), 32'd0);
    chk("t3_clr_sv", 32'(sv4), 32'd1);
    chk("t3_clr_sum", sum4, 32'd100);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("t3_accept", 32'(sv4), 32'd0);
    // Second group completes on the same edge the first is accepted
    for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
    chk("t3_sum_c", sum4, 32'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd2, 1'b0, 1'b0);
    step(1'b1, 16'd2, 1'b0, 1'b1);
    chk("t3_sum_d", sum4, 32'd8);
    chk("t3_sv_d", 32'(sv4), 32'd1);
    chk("t3_ovr_d", 32'(ov4), 32'd0);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("t3_drop_d", 32'(sv4), 32'd0);

    // Clear mid-group discards partial sum
    step(1'b1, 16'd100, 1'b0, 1'b0);
    step(1'b1, 16'd200, 1'b0, 1'b0);
    chk("t4_cnt2", 32'(cnt4), 32'd2);
    step(1'b0, 16'd0, 1'b1, 1'b0);
    chk("t4_cnt_clr", 32'(cnt4), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
    chk("t4_sum", sum4, 32'd4);
    chk("t4_sv", 32'(sv4), 32'd1);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    // Clear coincident with a valid product: product is dropped
    step(1'b1, 16'd7, 1'b0, 1'b0);
    step(1'b1, 16'd1000, 1'b1, 1'b0);
    chk("t4_cnt_clrv", 32'(cnt4), 32'd0);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(10 * i), 1'b0, 1'b0);
    chk("t4_sum_clrv", sum4, 32'd100);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // Reset mid-group with a pending result
    for (int i = 0; i < 4; i++) step(1'b1, 16'd9, 1'b0, 1'b0);
    chk("t5_pend", sum4, 32'd36);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd1, 1'b0, 1'b0);
    chk("t5_cnt3", 32'(cnt4), 32'd3);
    rst = 1'b0;
    #1;
    chk("t5_rst_sum", sum4, 32'd0);
    chk("t5_rst_sv", 32'(sv4), 32'd0);
    chk("t5_rst_cnt", 32'(cnt4), 32'd0);
    chk("t5_rst_ovr", 32'(ov4), 32'd0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 16'd65025, 1'b0, 1'b0);
    chk("t5_sum", sum4, 32'd260100);
    chk("t5_sv", 32'(sv4), 32'd1);
    step(1'b0, 16'd0, 1'b0, 1'b1);

    // K=8 instance: fresh start, three continuous maximal groups
    chk("t6_pre_cnt", 32'(cnt8), 32'd4);
    rst = 1'b0;
    #1;
    chk("t6_rst_cnt", 32'(cnt8), 32'd0);
    chk("t6_rst_sv", 32'(sv8), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 16'd65025, 1'b0, 1'b1);
      chk("t6_cnt", 32'(cnt8), 32'((i + 1) % 8));
      chk("t6_sv", 32'(sv8), 32'(((i + 1) % 8) == 0));
      if (((i + 1) % 8) == 0) chk("t6_sum", sum8, 32'd520200);
    end
    chk("t6_ovr", 32'(ov8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dot_accumulator

// File: doc/dot_accumulator.md
# dot_accumulator

Downstream consumer of `pip_multiplier` in the systolic matrix-multiply datapath. Sums a fixed number `K` of valid 16-bit unsigned products into one dot-product result, tolerating input bubbles. Holds each finished result in an output register with a valid/ready handshake toward the result collector. Accumulation of the next group continues while a result waits.

## Interface
- `PROD_W`, 16, width of incoming product (matches multiplier output)
- `ACC_W`, 32, width of accumulator and result; must satisfy `ACC_W >= PROD_W + $clog2(K)` (elaboration-time assertion)
- `K`, 8, number of valid products per dot product; must be >= 1
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-low reset (0 = reset asserted)
- `product`  input  PROD_W  multiplier result, unsigned
- `valid_in`  input  1  `product` is valid this cycle (driven from multiplier `valid_out`)
- `clear`  input  1  synchronous flush of the in-progress group
- `sum`  output  ACC_W  finished dot-product result
- `sum_valid`  output  1  `sum` holds an unconsumed result
- `sum_ready`  input  1  downstream accepts `sum` when high with `sum_valid`
- `count`  output  $clog2(K+1)  valid products absorbed in the current group
- `overrun`  output  1  sticky: a finished result was overwritten before acceptance

## Operation
- No backpressure upstream: every `valid_in` product is absorbed; the multiplier has no ready.
- Accumulate: on an edge with `valid_in=1` and `clear=0`, `acc <= acc + zext(product)`, `count <= count+1`.
- Completion: the edge absorbing the K-th product loads `sum <= acc + zext(product)`, sets `sum_valid`, and returns `acc` and `count` to 0. There is no idle gap; the next product starts a new group.
- Bubbles (`valid_in=0`) leave `acc`/`count` unchanged; any number is allowed between products.
- Output FSM, two states:
  - EMPTY: `sum_valid=0`; goes to FULL on completion.
  - FULL: `sum_valid=1`; goes to EMPTY on `sum_ready`, unless a completion happens on that same edge, in which case it stays FULL with the new `sum` and no overrun.
  - FULL with completion and `sum_ready=0`: `sum` is overwritten and `overrun` is set.
- `clear` zeroes `acc` and `count` and clears `overrun`. It does not touch `sum`/`sum_valid`. `clear` with `valid_in` on the same edge: clear wins and the product is discarded.
- Arithmetic is unsigned and wraps modulo 2^ACC_W. With the width assertion satisfied, wrap cannot occur.
- `sum` is stable while `sum_valid=1` until accepted or overwritten.

## Timing
- Reset values (async, immediate): `acc=0`, `count=0`, `sum=0`, `sum_valid=0`, `overrun=0`. The FSM enters EMPTY.
- Latency: `sum_valid` and `sum` are visible one cycle after the edge that samples the K-th valid product.
- Throughput: one product per cycle. One result per K valid cycles.
- Handshake: transfer occurs on an edge where `sum_valid && sum_ready`. `sum_ready` may be high while EMPTY with no effect.
- Reset asserted mid-group or while FULL discards everything. The first valid product after release starts a fresh group.
- `count` reads K-1 at most; it never shows K.

## Structure
- Shared package `mat_mul_pkg`: `DATA_W=8`, `PROD_W=16`, `ACC_W=32`, and the output FSM enum `out_state_t {OUT_EMPTY, OUT_FULL}`. The multiplier and this block both import it.
- One sub-module: `group_counter`, a modulo-K counter with enable and sync clear, producing `count` and a `wrap` pulse on the K-th increment.
- Datapath adder, `acc` register, result register, and FSM live in `dot_accumulator`.

## Test plan
- K=4, products 91, 65025, 0, 256 back-to-back -> `sum=65372`, `sum_valid` high one cycle after the 4th, `sum_ready=1` -> drops next cycle.
- Same four products with 2-cycle bubbles between each -> identical `sum=65372`; `count` steps 1, 2, 3, 0 only on valid cycles.
- Two groups back-to-back, `sum_ready=0` throughout -> second `sum` replaces the first and `overrun=1`. Repeat with `sum_ready=1` on the completion edge of group 2 -> `overrun=0`, `sum_valid` stays 1.
- `clear` after 2 products (100, 200), then 4 products of 1 -> `sum=4`. `clear` coincident with `valid_in` -> that product is excluded.
- Reset asserted after 3 products with a pending result -> all outputs 0 immediately. After release, 4 products of 65025 -> `sum=260100`.
- K=8, all inputs 65025 (255x255) continuously for 3 groups -> each `sum=520200`, no wrap, one `sum_valid` per 8 cycles.
